mem_arbiter: RTL and testbench

Sequential arbiter between the request unit's memory enables and the single shared RAM port. Accepts one instruction-read or data-read/write request at a time, gives data priority, holds the RAM request stable until the RAM reports completion, then returns registered load data and a one-cycle hit (wait low) to the datapath. Sits directly downstream of the request unit and upstream of the RAM model.

---
 rtl/mem_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between the request unit and the RAM.
//
// One access is outstanding at a time. Data requests (write over read) beat
// instruction fetches, and fetches are not started while halt_out is high.
// The granted address, store data and operation are latched and held on the
// RAM port until the RAM reports ACCESS or ERROR, or until the access has been
// outstanding for TIMEOUT cycles. The result is presented for one cycle in a
// DONE state (iwait or dwait low) with registered load data; the following
// DONE->IDLE cycle gives the request unit time to drop its enable.
//
// Optional feature: define MEM_ARB_STATS_EN to add icount/dcount outputs that
// count completed instruction and data accesses (errors included).

module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,

    // request unit side
    input  logic        imemREN,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        halt_out,
    input  logic [31:0] imemaddr,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        mem_err,

    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] icount,
    output logic [31:0] dcount
`endif
);

    // FSM encoding
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] IACC  = 3'd1;
    localparam logic [2:0] DACC  = 3'd2;
    localparam logic [2:0] IDONE = 3'd3;
    localparam logic [2:0] DDONE = 3'd4;

    // RAM status codes that end an access; FREE and BUSY just keep counting
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    // The access is forced to error on the TIMEOUT-th ACC cycle, i.e. when
    // TIMEOUT-1 cycles have already been counted.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    // Timeout counter step; holds at all-ones so it can never wrap back to
    // a value that looks fresh.
    function automatic logic [15:0] cnt_step(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [2:0]  state_q, state_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic [31:0] iload_q, iload_d;
    logic [31:0] dload_q, dload_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    logic        in_acc;
    logic        acc_hit;
    logic        acc_fail;
    logic        grant_d;
    logic        grant_w;
    logic        grant_i;

    // Request priority: data write, then data read, then unhalted fetch
    always_comb begin
        grant_w = dmemWEN;
        grant_d = dmemWEN | dmemREN;
        grant_i = ~grant_d & imemREN & ~halt_out;
    end

    // Access resolution for the current ACC cycle; ACCESS wins over timeout
    always_comb begin
        in_acc   = (state_q == IACC) || (state_q == DACC);
        acc_hit  = in_acc && (ramstate == RAM_ACCESS);
        acc_fail = in_acc && !acc_hit &&
                   ((ramstate == RAM_ERROR) || (cnt_q == TO_LAST));
    end

    // Next-state, latched request and load/error update
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        store_d = store_q;
        iload_d = iload_q;
        dload_d = dload_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = DACC;
                    wr_d    = grant_w;
                    addr_d  = dmemaddr;
                    cnt_d   = 16'd0;
                    if (grant_w) begin
                        store_d = dmemstore;
                    end
                end else if (grant_i) begin
                    state_d = IACC;
                    wr_d    = 1'b0;
                    addr_d  = imemaddr;
                    cnt_d   = 16'd0;
                end
            end

            IACC: begin
                cnt_d = cnt_step(cnt_q);
                if (acc_hit) begin
                    state_d = IDONE;
                    iload_d = ramload;
                end else if (acc_fail) begin
                    state_d = IDONE;
                    iload_d = ERR_WORD;
                    err_d   = 1'b1;
                end
            end

            DACC: begin
                cnt_d = cnt_step(cnt_q);
                if (acc_hit) begin
                    state_d = DDONE;
                    if (!wr_q) begin
                        dload_d = ramload;
                    end
                end else if (acc_fail) begin
                    state_d = DDONE;
                    dload_d = ERR_WORD;
                    err_d   = 1'b1;
                end
            end

            IDONE:   state_d = IDLE;
            DDONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, including loads
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            store_q <= 32'd0;
            iload_q <= 32'd0;
            dload_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] icnt_q, icnt_d;
    logic [31:0] dcnt_q, dcnt_d;

    // Completion counters bump on entry to the DONE states (wrapping)
    always_comb begin
        icnt_d = icnt_q;
        dcnt_d = dcnt_q;
        if ((state_q == IACC) && (state_d == IDONE)) begin
            icnt_d = icnt_q + 32'd1;
        end
        if ((state_q == DACC) && (state_d == DDONE)) begin
            dcnt_d = dcnt_q + 32'd1;
        end
    end

    // Completion counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icnt_q <= 32'd0;
            dcnt_q <= 32'd0;
        end else begin
            icnt_q <= icnt_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign icount = icnt_q;
    assign dcount = dcnt_q;
`endif

    // Outputs are pure decodes of registered state, so the RAM status never
    // reaches the wait lines combinationally and reset drops strobes at once.
    assign iwait    = (state_q != IDONE);
    assign dwait    = (state_q != DDONE);
    assign ramREN   = (state_q == IACC) || ((state_q == DACC) && !wr_q);
    assign ramWEN   = (state_q == DACC) && wr_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign mem_err  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (TIMEOUT overridden to 4).
// A transaction-level model decides which accesses are served, in what order,
// how many ACC cycles each lasts and what it returns; the bench then walks the
// cycles and compares every output. Define MEM_ARB_STATS_EN to cover counters.

module tb_mem_arbiter;

    localparam int          TO   = 4;
    localparam logic [31:0] ERRW = 32'hBAD1BAD1;
    localparam logic [1:0]  S_FREE   = 2'd0;
    localparam logic [1:0]  S_BUSY   = 2'd1;
    localparam logic [1:0]  S_ACCESS = 2'd2;
    localparam logic [1:0]  S_ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN, dmemREN, dmemWEN, halt_out;
    logic [31:0] imemaddr, dmemaddr, dmemstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        mem_err, ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] icount, dcount;
`endif

    always #5 CLK = ~CLK;

    mem_arbiter #(.TIMEOUT(TO), .ERR_WORD(ERRW)) dut (
        .CLK(CLK), .nRST(nRST),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .halt_out(halt_out),
        .imemaddr(imemaddr), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .mem_err(mem_err),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
`ifdef MEM_ARB_STATS_EN
        , .icount(icount), .dcount(dcount)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;

    // model state visible at the outputs
    logic [31:0] exp_iload, exp_dload;
    logic        exp_err;
    int          exp_ic, exp_dc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic chk_outs(input string tag, input logic iw, input logic dw,
                            input logic ren, input logic wen);
        check({tag, ".iwait"},   iwait,   iw);
        check({tag, ".dwait"},   dwait,   dw);
        check({tag, ".ramREN"},  ramREN,  ren);
        check({tag, ".ramWEN"},  ramWEN,  wen);
        check({tag, ".iload"},   iload,   exp_iload);
        check({tag, ".dload"},   dload,   exp_dload);
        check({tag, ".mem_err"}, mem_err, exp_err);
    endtask

    task automatic model_reset();
        exp_iload = 32'd0;
        exp_dload = 32'd0;
        exp_err   = 1'b0;
        exp_ic    = 0;
        exp_dc    = 0;
    endtask

    // Serve one access. Entry: just after the edge that starts the IDLE cycle
    // in which this request is visible. Exit: just after the edge that starts
    // the IDLE cycle following DONE, with this request's enable dropped.
    task automatic serve(input bit is_d, input bit is_w, input logic [31:0] addr,
                         input logic [31:0] store, input int busy, input bit err,
                         input logic [31:0] rdata, input bit raise_halt);
        int          nacc;
        bit          fail;
        logic [31:0] sv_ia, sv_da, sv_ds;
        nacc  = (busy >= TO) ? TO : busy + 1;
        fail  = err || (busy >= TO);
        sv_ia = imemaddr;
        sv_da = dmemaddr;
        sv_ds = dmemstore;
        sample();
        chk_outs("idle", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        for (int j = 0; j < nacc; j++) begin
            if (raise_halt && j == 0) halt_out = 1'b1;
            // request-side inputs change while the access is in flight
            if (is_d) begin
                dmemaddr  = $urandom;
                dmemstore = $urandom;
            end else begin
                imemaddr = $urandom;
            end
            if (j < busy) begin
                ramstate = S_BUSY;
                ramload  = $urandom;
            end else if (err) begin
                ramstate = S_ERROR;
                ramload  = $urandom;
            end else begin
                ramstate = S_ACCESS;
                ramload  = rdata;
            end
            sample();
            chk_outs("acc", 1'b1, 1'b1, !is_w, is_w);
            check("acc.ramaddr", ramaddr, addr);
            if (is_w) check("acc.ramstore", ramstore, store);
            tick();
        end
        ramstate  = S_FREE;
        ramload   = $urandom;
        imemaddr  = sv_ia;
        dmemaddr  = sv_da;
        dmemstore = sv_ds;
        if (fail) begin
            exp_err = 1'b1;
            if (is_d) exp_dload = ERRW;
            else      exp_iload = ERRW;
        end else if (!is_d) begin
            exp_iload = rdata;
        end else if (!is_w) begin
            exp_dload = rdata;
        end
        if (is_d) exp_dc++;
        else      exp_ic++;
        sample();
        chk_outs("done", is_d, !is_d, 1'b0, 1'b0);
`ifdef MEM_ARB_STATS_EN
        check("done.icount", icount, exp_ic);
        check("done.dcount", dcount, exp_dc);
`endif
        tick();
        if (is_d) begin
            dmemREN = 1'b0;
            dmemWEN = 1'b0;
        end else begin
            imemREN = 1'b0;
        end
    endtask

    // One group of simultaneous requests from the request unit.
    task automatic run_group(input bit ireq, input bit dr, input bit dw, input bit halt,
                             input bit halt_mid, input int ibusy, input int dbusy,
                             input bit ierr, input bit derr,
                             input logic [31:0] iaddr, input logic [31:0] daddr,
                             input logic [31:0] dstore, input logic [31:0] irdata,
                             input logic [31:0] drdata);
        bit do_d, do_i;
        do_d = dr | dw;
        do_i = ireq && !halt && !(halt_mid && do_d);
        imemREN   = ireq;
        dmemREN   = dr;
        dmemWEN   = dw;
        halt_out  = halt;
        imemaddr  = iaddr;
        dmemaddr  = daddr;
        dmemstore = dstore;
        ramstate  = S_FREE;
        ramload   = $urandom;
        if (do_d) serve(1'b1, dw, daddr, dstore, dbusy, derr, drdata, halt_mid);
        if (do_i) serve(1'b0, 1'b0, iaddr, 32'd0, ibusy, ierr, irdata, halt_mid && !do_d);
        if (!do_i) begin
            repeat (2) begin
                sample();
                chk_outs("blocked", 1'b1, 1'b1, 1'b0, 1'b0);
                tick();
            end
        end
        imemREN  = 1'b0;
        dmemREN  = 1'b0;
        dmemWEN  = 1'b0;
        halt_out = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt_out = 1'b0;
        imemaddr = 32'd0; dmemaddr = 32'd0; dmemstore = 32'd0;
        ramload = 32'd0; ramstate = S_FREE;
        model_reset();

        // reset values
        repeat (2) @(posedge CLK);
        sample();
        chk_outs("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        check("reset.ramaddr", ramaddr, 32'd0);
        check("reset.ramstore", ramstore, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // fetch with immediate ACCESS
        run_group(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 32'h0, 32'h0, 32'h8C220004, 32'h0);
        // fetch and write together: write first, then fetch
        run_group(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h44, 32'h100, 32'hDEADBEEF, 32'h11112222, 32'h0);
        // data read with three BUSY cycles
        run_group(0, 1, 0, 0, 0, 0, 3, 0, 0, 32'h0, 32'h204, 32'h0, 32'h0, 32'hCAFEF00D);
        // fetch error, then fetch timeout
        run_group(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h48, 32'h0, 32'h0, 32'h55555555, 32'h0);
        run_group(1, 0, 0, 0, 0, TO + 2, 0, 0, 0, 32'h4C, 32'h0, 32'h0, 32'h66666666, 32'h0);
        // halt raised mid-fetch, then halted fetch blocked but write granted
        run_group(1, 0, 0, 0, 1, 1, 0, 0, 0, 32'h50, 32'h0, 32'h0, 32'h77777777, 32'h0);
        run_group(1, 0, 1, 1, 0, 0, 1, 0, 0, 32'h54, 32'h300, 32'h0BADF00D, 32'h0, 32'h0);
        run_group(1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h58, 32'h0, 32'h0, 32'h0, 32'h0);

        // reset asserted in the middle of a data write
        dmemWEN = 1'b1; dmemaddr = 32'h400; dmemstore = 32'h12345678;
        tick();
        ramstate = S_BUSY;
        #1;
        check("midrst.pre_wen", ramWEN, 1'b1);
        nRST = 1'b0;
        #1;
        model_reset();
        check("midrst.ramWEN", ramWEN, 1'b0);
        check("midrst.ramREN", ramREN, 1'b0);
        check("midrst.ramaddr", ramaddr, 32'd0);
        check("midrst.ramstore", ramstore, 32'd0);
        check("midrst.dwait", dwait, 1'b1);
        check("midrst.mem_err", mem_err, 1'b0);
        check("midrst.iload", iload, 32'd0);
        check("midrst.dload", dload, 32'd0);
        dmemWEN = 1'b0;
        ramstate = S_FREE;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        repeat (3) begin
            sample();
            chk_outs("postrst", 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end

        // three fetches and two data ops from a clean reset
        for (int k = 0; k < 3; k++)
            run_group(1, 0, 0, 0, 0, k, 0, 0, 0, 32'h1000 + k * 4, 32'h0, 32'h0, $urandom, 32'h0);
        run_group(0, 1, 0, 0, 0, 0, 2, 0, 0, 32'h0, 32'h2000, 32'h0, 32'h0, $urandom);
        run_group(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h2004, $urandom, 32'h0, 32'h0);
`ifdef MEM_ARB_STATS_EN
        check("stats.icount", icount, 32'd3);
        check("stats.dcount", dcount, 32'd2);
`endif

        // randomized groups
        for (int k = 0; k < 60; k++) begin
            run_group($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                      $urandom_range(0, 5), $urandom_range(0, 5),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                      $urandom, $urandom, $urandom, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
